hdp_spi_responder: RTL

// - SPI responder (target side) of the HDP display configuration link; models the HDP register file.
// - Decodes 16-bit frames from the FPGA-side SPI initiator: register writes, register reads with MISO return.
// - Used as the bench model for the startup/shutdown sequencer and as the config front-end of an emulated panel.

---
 rtl/hdp_spi_responder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/hdp_spi_responder.sv
// HDP display-link SPI responder: decodes 16-bit register frames and models the HDP register file.
// Optional aborted-frame counter at 0x7F is enabled by defining HDP_SPI_ABORT_COUNT_EN.
module hdp_spi_responder #(
    parameter logic [7:0] HW_ID       = 8'h20,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_sen,
    input  logic        i_sck,
    input  logic        i_sdat,
    output logic        o_sout,
    output logic [1:0]  o_mode,
    output logic [7:0]  o_clockMhz,
    output logic [15:0] o_serialRow,
    output logic [15:0] o_returnRow,
    output logic [15:0] o_currentRow,
    output logic        o_wrStrobe,
    output logic [6:0]  o_wrAddress,
    output logic [7:0]  o_wrData
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        COMMIT,
        WAIT_SEN
    } stateType;

    stateType state, stateNext;

    logic [SYNC_STAGES-1:0] senSync, sckSync, sdatSync;
    logic                   senPrev, sckPrev;
    logic                   sen, sck, sdat;
    logic                   senRise, senFall, sckRise, sckFall;

    logic [15:0] frameShift;
    logic [2:0]  bitCount;
    logic        isRead;
    logic [7:0]  shiftOut;
    logic [6:0]  cmdAddress;
    logic [7:0]  readData;
    logic        abortFrame;
    logic [6:0]  commitAddress;
    logic [7:0]  commitData;
`ifdef HDP_SPI_ABORT_COUNT_EN
    logic [7:0]  abortCount;
`endif

    assign sen  = senSync[SYNC_STAGES-1];
    assign sck  = sckSync[SYNC_STAGES-1];
    assign sdat = sdatSync[SYNC_STAGES-1];

    assign senRise = sen & ~senPrev;
    assign senFall = ~sen & senPrev;
    assign sckRise = sck & ~sckPrev;
    assign sckFall = ~sck & sckPrev;

    // Address byte is complete on the 8th CMD rising edge, including the bit arriving now.
    assign cmdAddress    = {frameShift[5:0], sdat};
    assign commitAddress = frameShift[14:8];
    assign commitData    = frameShift[7:0];

    // NOTE: the synchronisers reset to 0 (enable looks asserted), so a reset taken
    // mid-frame never produces an enable fall and the rest of that frame is ignored.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            senSync  <= '0;
            sckSync  <= '0;
            sdatSync <= '0;
            senPrev  <= 1'b0;
            sckPrev  <= 1'b0;
        end else begin
            senSync  <= {senSync[SYNC_STAGES-2:0], i_sen};
            sckSync  <= {sckSync[SYNC_STAGES-2:0], i_sck};
            sdatSync <= {sdatSync[SYNC_STAGES-2:0], i_sdat};
            senPrev  <= sen;
            sckPrev  <= sck;
        end
    end

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        stateNext  = state;
        abortFrame = 1'b0;
        unique case (state)
            IDLE: begin
                if (senFall) stateNext = CMD;
            end
            CMD: begin
                if (senRise) begin
                    stateNext  = IDLE;
                    abortFrame = 1'b1;
                end else if (sckRise && bitCount == 3'd7) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (senRise) begin
                    stateNext  = IDLE;
                    abortFrame = 1'b1;
                end else if (sckRise && bitCount == 3'd7) begin
                    stateNext = COMMIT;
                end
            end
            COMMIT:   stateNext = senRise ? IDLE : WAIT_SEN;
            WAIT_SEN: if (senRise) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_comb begin
        readData = 8'h00;
        case (cmdAddress)
            7'h01:   readData = {6'b0, o_mode};
            7'h06:   readData = o_serialRow[15:8];
            7'h07:   readData = o_serialRow[7:0];
            7'h09:   readData = o_clockMhz;
            7'h78:   readData = HW_ID;
`ifdef HDP_SPI_ABORT_COUNT_EN
            7'h7F:   readData = abortCount;
`endif
            default: readData = 8'h00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= IDLE;
            frameShift   <= '0;
            bitCount     <= '0;
            isRead       <= 1'b0;
            shiftOut     <= '0;
            o_sout       <= 1'b0;
            o_mode       <= '0;
            o_clockMhz   <= '0;
            o_serialRow  <= '0;
            o_returnRow  <= '0;
            o_currentRow <= '0;
            o_wrStrobe   <= 1'b0;
            o_wrAddress  <= '0;
            o_wrData     <= '0;
`ifdef HDP_SPI_ABORT_COUNT_EN
            abortCount   <= '0;
`endif
        end else begin
            state      <= stateNext;
            o_wrStrobe <= 1'b0;

            if (state == IDLE) begin
                bitCount <= '0;
            end else if ((state == CMD || state == DATA) && sckRise) begin
                frameShift <= {frameShift[14:0], sdat};
                bitCount   <= bitCount + 3'd1;
            end

            if (state == CMD && sckRise && bitCount == 3'd7) begin
                isRead   <= frameShift[6];
                shiftOut <= readData;
            end

            if (stateNext != DATA) begin
                o_sout <= 1'b0;
            end else if (state == DATA && sckFall && isRead) begin
                o_sout   <= shiftOut[7];
                shiftOut <= {shiftOut[6:0], 1'b0};
            end

            if (state == COMMIT && !frameShift[15]) begin
                o_wrStrobe  <= 1'b1;
                o_wrAddress <= commitAddress;
                o_wrData    <= commitData;
                case (commitAddress)
                    7'h01: if (commitData <= 8'd2) o_mode <= commitData[1:0];
                    7'h06: o_serialRow[15:8] <= commitData;
                    7'h07: o_serialRow[7:0]  <= commitData;
                    7'h08: begin
                        if (commitData == 8'h30) o_returnRow  <= o_serialRow;
                        if (commitData == 8'h40) o_currentRow <= o_serialRow;
                    end
                    7'h09: o_clockMhz <= commitData;
`ifdef HDP_SPI_ABORT_COUNT_EN
                    7'h7F: abortCount <= '0;
`endif
                    default: ;
                endcase
            end

`ifdef HDP_SPI_ABORT_COUNT_EN
            if (abortFrame && abortCount != 8'hFF) abortCount <= abortCount + 8'd1;
`endif
        end
    end

endmodule
